// File: rtl/nmi_arb_pkg.sv
// Shared types and widths for the NMI round-robin arbiter.
package nmi_arb_pkg;

    localparam int unsigned NMI_AW = 32;
    localparam int unsigned NMI_DW = 32;
    localparam int unsigned NMI_SW = 4;

    localparam logic [NMI_DW-1:0] TIMEOUT_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } arb_state_e;

endpackage

// File: rtl/nmi_arbiter_if.sv
// Bundle of master-side and bus-side NMI signals around the arbiter.
interface nmi_arbiter_if #(
    parameter int unsigned NUM_MST = 2
);
    import nmi_arb_pkg::*;

    logic [NUM_MST-1:0]             mst_valid_i;
    logic [NUM_MST-1:0][NMI_AW-1:0] mst_addr_i;
    logic [NUM_MST-1:0][NMI_DW-1:0] mst_wdata_i;
    logic [NUM_MST-1:0][NMI_SW-1:0] mst_wstrb_i;
    logic [NUM_MST-1:0][NMI_DW-1:0] mst_rdata_o;
    logic [NUM_MST-1:0]             mst_ready_o;
    logic                           slv_valid_o;
    logic [NMI_AW-1:0]              slv_addr_o;
    logic [NMI_DW-1:0]              slv_wdata_o;
    logic [NMI_SW-1:0]              slv_wstrb_o;
    logic [NMI_DW-1:0]              slv_rdata_i;
    logic                           slv_ready_i;
    logic [NUM_MST-1:0]             grant_o;
    logic                           timeout_o;

    // Arbiter view.
    modport slave (
        input  mst_valid_i, mst_addr_i, mst_wdata_i, mst_wstrb_i, slv_rdata_i, slv_ready_i,
        output mst_rdata_o, mst_ready_o, slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
               grant_o, timeout_o
    );

    // Environment view: requesters plus the downstream bus.
    modport master (
        output mst_valid_i, mst_addr_i, mst_wdata_i, mst_wstrb_i, slv_rdata_i, slv_ready_i,
        input  mst_rdata_o, mst_ready_o, slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
               grant_o, timeout_o
    );

endinterface

// File: rtl/nmi_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after the pointer, with wrap.
module rr_pick #(
    parameter int unsigned NUM_MST = 2,
    parameter int unsigned PTR_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic [NUM_MST-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_MST-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx
);

    int unsigned w_start;
    int unsigned w_cand;
    logic        w_found;

    always_comb begin
        // Pointer codes beyond the last master restart the search at 0.
        w_start = (32'(i_ptr) < NUM_MST) ? 32'(i_ptr) : 32'd0;
        w_cand  = 0;
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int unsigned k = 0; k < NUM_MST; k++) begin
            w_cand = w_start + k;
            if (w_cand >= NUM_MST) begin
                w_cand = w_cand - NUM_MST;
            end
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = PTR_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin NMI arbiter with transaction lock and watchdog error response.
module nmi_arbiter
    import nmi_arb_pkg::*;
#(
    parameter int unsigned       NUM_MST       = 2,
    parameter int unsigned       TIMEOUT_CYC   = 1024,
    parameter logic [NMI_DW-1:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEF
) (
    input logic          clk_i,
    input logic          rst_n_i,
    nmi_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_e         r_state, w_state_d;
    logic [NUM_MST-1:0] r_grant, w_grant_d;
    logic [PTR_W-1:0]   r_idx, w_idx_d;
    logic [PTR_W-1:0]   r_ptr, w_ptr_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;

    logic [NUM_MST-1:0]             w_pick_gnt;
    logic [PTR_W-1:0]               w_pick_idx;
    logic [PTR_W-1:0]               w_ptr_next;
    logic [NUM_MST-1:0]             w_mst_ready;
    logic [NUM_MST-1:0][NMI_DW-1:0] w_mst_rdata;
    logic                           w_slv_valid;
    logic                           w_timeout;
    logic                           w_expired;

    rr_pick #(
        .NUM_MST (NUM_MST),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req (bus.mst_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    assign w_ptr_next = (32'(r_idx) == NUM_MST - 1) ? '0 : r_idx + 1'b1;
    assign w_expired  = (TIMEOUT_CYC > 0) && (32'(r_cnt) == TIMEOUT_CYC - 1);

    always_comb begin
        w_state_d   = r_state;
        w_grant_d   = r_grant;
        w_idx_d     = r_idx;
        w_ptr_d     = r_ptr;
        w_cnt_d     = r_cnt;
        w_slv_valid = 1'b0;
        w_mst_ready = '0;
        w_mst_rdata = '0;
        w_timeout   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|bus.mst_valid_i) begin
                    w_state_d = StBusy;
                    w_grant_d = w_pick_gnt;
                    w_idx_d   = w_pick_idx;
                    w_cnt_d   = '0;
                end
            end
            StBusy: begin
                w_slv_valid = 1'b1;
                if (!bus.mst_valid_i[r_idx]) begin
                    // Requester withdrew mid-transaction: abandon it silently.
                    w_state_d = StIdle;
                    w_grant_d = '0;
                    w_ptr_d   = w_ptr_next;
                end else if (bus.slv_ready_i) begin
                    w_mst_ready[r_idx] = 1'b1;
                    w_mst_rdata[r_idx] = bus.slv_rdata_i;
                    w_state_d          = StIdle;
                    w_grant_d          = '0;
                    w_ptr_d            = w_ptr_next;
                end else if (w_expired) begin
                    w_mst_ready[r_idx] = 1'b1;
                    w_mst_rdata[r_idx] = TIMEOUT_RDATA;
                    w_timeout          = 1'b1;
                    w_state_d          = StIdle;
                    w_grant_d          = '0;
                    w_ptr_d            = w_ptr_next;
                end else if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_idx   <= w_idx_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign bus.grant_o     = r_grant;
    assign bus.slv_valid_o = w_slv_valid;
    assign bus.slv_addr_o  = w_slv_valid ? bus.mst_addr_i[r_idx]  : '0;
    assign bus.slv_wdata_o = w_slv_valid ? bus.mst_wdata_i[r_idx] : '0;
    assign bus.slv_wstrb_o = w_slv_valid ? bus.mst_wstrb_i[r_idx] : '0;
    assign bus.mst_ready_o = w_mst_ready;
    assign bus.mst_rdata_o = w_mst_rdata;
    assign bus.timeout_o   = w_timeout;

endmodule

// File: tb/tb_nmi_arbiter.sv
// Directed table-driven bench for nmi_arbiter (2 masters, 8-cycle watchdog).
module tb_nmi_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    nmi_arbiter_if #(.NUM_MST(2)) bus ();

    nmi_arbiter #(
        .NUM_MST       (2),
        .TIMEOUT_CYC   (8),
        .TIMEOUT_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic        rdy;
        logic [31:0] rdata;
        logic [1:0]  e_grant;
        logic        e_sv;
        logic [1:0]  e_rdy;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slv(input string name, input logic [1:0] g, input logic sv);
        logic [31:0] ea, ew, es;
        ea = 32'h0;
        ew = 32'h0;
        es = 32'h0;
        if (sv && g == 2'b01) begin
            ea = 32'h0300_0010;
        end else if (sv && g == 2'b10) begin
            ea = 32'h0400_0020;
            ew = 32'hCAFE_F00D;
            es = 32'h3;
        end
        chk({name, "_addr"}, bus.slv_addr_o, ea);
        chk({name, "_wdata"}, bus.slv_wdata_o, ew);
        chk({name, "_wstrb"}, {28'h0, bus.slv_wstrb_o}, es);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.mst_valid_i    = '0;
        bus.mst_addr_i[0]  = 32'h0300_0010;
        bus.mst_wdata_i[0] = 32'h0;
        bus.mst_wstrb_i[0] = 4'b0000;
        bus.mst_addr_i[1]  = 32'h0400_0020;
        bus.mst_wdata_i[1] = 32'hCAFE_F00D;
        bus.mst_wstrb_i[1] = 4'b0011;
        bus.slv_rdata_i    = '0;
        bus.slv_ready_i    = 1'b0;

        // valid, rdy, rdata | grant, slv_valid, mst_ready, rdata0, rdata1
        tbl[0]  = '{2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[1]  = '{2'b01, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[2]  = '{2'b01, 1'b0, 32'h0,         2'b01, 1'b1, 2'b00, 32'h0,         32'h0};
        tbl[3]  = '{2'b01, 1'b0, 32'hFFFF_0000, 2'b01, 1'b1, 2'b00, 32'h0,         32'h0};
        tbl[4]  = '{2'b01, 1'b1, 32'h1234_5678, 2'b01, 1'b1, 2'b01, 32'h1234_5678, 32'h0};
        tbl[5]  = '{2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[6]  = '{2'b10, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[7]  = '{2'b10, 1'b0, 32'h0,         2'b10, 1'b1, 2'b00, 32'h0,         32'h0};
        tbl[8]  = '{2'b10, 1'b1, 32'h1111_0000, 2'b10, 1'b1, 2'b10, 32'h0,         32'h1111_0000};
        tbl[9]  = '{2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[10] = '{2'b11, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[11] = '{2'b11, 1'b1, 32'h0000_00A0, 2'b01, 1'b1, 2'b01, 32'h0000_00A0, 32'h0};
        tbl[12] = '{2'b11, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[13] = '{2'b11, 1'b1, 32'h0000_00B1, 2'b10, 1'b1, 2'b10, 32'h0,         32'h0000_00B1};
        tbl[14] = '{2'b11, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[15] = '{2'b11, 1'b1, 32'h0000_00C2, 2'b01, 1'b1, 2'b01, 32'h0000_00C2, 32'h0};
        tbl[16] = '{2'b11, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[17] = '{2'b11, 1'b1, 32'h0000_00D3, 2'b10, 1'b1, 2'b10, 32'h0,         32'h0000_00D3};
        tbl[18] = '{2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0,         32'h0};

        step();
        step();
        chk("rst_grant", {30'h0, bus.grant_o}, 32'h0);
        chk("rst_slv_valid", {31'h0, bus.slv_valid_o}, 32'h0);
        chk("rst_mst_ready", {30'h0, bus.mst_ready_o}, 32'h0);
        chk("rst_timeout", {31'h0, bus.timeout_o}, 32'h0);
        chk("rst_rdata0", bus.mst_rdata_o[0], 32'h0);
        chk_slv("rst", 2'b00, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            bus.mst_valid_i = tbl[i].valid;
            bus.slv_ready_i = tbl[i].rdy;
            bus.slv_rdata_i = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_grant", i), {30'h0, bus.grant_o}, {30'h0, tbl[i].e_grant});
            chk($sformatf("v%0d_slv_valid", i), {31'h0, bus.slv_valid_o}, {31'h0, tbl[i].e_sv});
            chk($sformatf("v%0d_mst_ready", i), {30'h0, bus.mst_ready_o}, {30'h0, tbl[i].e_rdy});
            chk($sformatf("v%0d_rdata0", i), bus.mst_rdata_o[0], tbl[i].e_rd0);
            chk($sformatf("v%0d_rdata1", i), bus.mst_rdata_o[1], tbl[i].e_rd1);
            chk($sformatf("v%0d_timeout", i), {31'h0, bus.timeout_o}, 32'h0);
            chk_slv($sformatf("v%0d", i), tbl[i].e_grant, tbl[i].e_sv);
            step();
        end

        // Watchdog: M0, slave never answers.
        bus.mst_valid_i = 2'b01;
        bus.slv_ready_i = 1'b0;
        bus.slv_rdata_i = 32'h0;
        step();
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("to%0d_slv_valid", c), {31'h0, bus.slv_valid_o}, 32'h1);
            if (c < 8) begin
                chk($sformatf("to%0d_mst_ready", c), {30'h0, bus.mst_ready_o}, 32'h0);
                chk($sformatf("to%0d_timeout", c), {31'h0, bus.timeout_o}, 32'h0);
            end else begin
                chk("to_fire_mst_ready", {30'h0, bus.mst_ready_o}, 32'h1);
                chk("to_fire_rdata", bus.mst_rdata_o[0], 32'hDEAD_BEEF);
                chk("to_fire_timeout", {31'h0, bus.timeout_o}, 32'h1);
            end
            step();
        end
        bus.mst_valid_i = 2'b00;
        #1;
        chk("to_after_slv_valid", {31'h0, bus.slv_valid_o}, 32'h0);
        chk("to_after_grant", {30'h0, bus.grant_o}, 32'h0);
        chk("to_after_timeout", {31'h0, bus.timeout_o}, 32'h0);
        step();

        // Slave answers in the same cycle the watchdog would expire.
        bus.mst_valid_i = 2'b01;
        step();
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                bus.slv_ready_i = 1'b1;
                bus.slv_rdata_i = 32'hA5A5_A5A5;
            end
            #1;
            if (c == 8) begin
                chk("rx_mst_ready", {30'h0, bus.mst_ready_o}, 32'h1);
                chk("rx_rdata", bus.mst_rdata_o[0], 32'hA5A5_A5A5);
                chk("rx_timeout", {31'h0, bus.timeout_o}, 32'h0);
            end else begin
                chk($sformatf("rx%0d_mst_ready", c), {30'h0, bus.mst_ready_o}, 32'h0);
            end
            step();
        end
        bus.mst_valid_i = 2'b00;
        bus.slv_ready_i = 1'b0;
        bus.slv_rdata_i = 32'h0;
        #1;
        chk("rx_after_grant", {30'h0, bus.grant_o}, 32'h0);
        step();

        // Reset while M1 owns the bus (pointer is 1 here).
        bus.mst_valid_i = 2'b11;
        step();
        chk("mr_grant_m1", {30'h0, bus.grant_o}, 32'h2);
        bus.slv_ready_i = 1'b1;
        bus.slv_rdata_i = 32'h5555_AAAA;
        rst_n = 1'b0;
        #1;
        chk("mr_grant", {30'h0, bus.grant_o}, 32'h0);
        chk("mr_slv_valid", {31'h0, bus.slv_valid_o}, 32'h0);
        chk("mr_mst_ready", {30'h0, bus.mst_ready_o}, 32'h0);
        chk("mr_rdata1", bus.mst_rdata_o[1], 32'h0);
        chk("mr_timeout", {31'h0, bus.timeout_o}, 32'h0);
        chk_slv("mr", 2'b00, 1'b0);
        bus.slv_ready_i = 1'b0;
        bus.slv_rdata_i = 32'h0;
        step();
        chk("mr_hold_grant", {30'h0, bus.grant_o}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("mr_post_grant_m0", {30'h0, bus.grant_o}, 32'h1);
        bus.slv_ready_i = 1'b1;
        bus.slv_rdata_i = 32'h0000_0077;
        #1;
        chk("mr_post_ready", {30'h0, bus.mst_ready_o}, 32'h1);
        chk("mr_post_rdata", bus.mst_rdata_o[0], 32'h0000_0077);
        step();

        // Granted master drops valid while busy: abort, no ready, pointer moves on.
        bus.mst_valid_i = 2'b10;
        bus.slv_ready_i = 1'b0;
        bus.slv_rdata_i = 32'h0;
        step();
        chk("ab_grant_m1", {30'h0, bus.grant_o}, 32'h2);
        bus.mst_valid_i = 2'b00;
        #1;
        chk("ab_mst_ready", {30'h0, bus.mst_ready_o}, 32'h0);
        step();
        chk("ab_grant", {30'h0, bus.grant_o}, 32'h0);
        chk("ab_slv_valid", {31'h0, bus.slv_valid_o}, 32'h0);
        bus.mst_valid_i = 2'b11;
        step();
        chk("ab_next_grant_m0", {30'h0, bus.grant_o}, 32'h1);
        bus.slv_ready_i = 1'b1;
        step();
        bus.mst_valid_i = 2'b00;
        bus.slv_ready_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
